// File: rtl/pipe_pkg.sv
// Shared encodings for the execute stage: ALU ops and operand/store-data selects.
package pipe_pkg;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_SLL = 3'd5;
  localparam logic [2:0] ALU_SRL = 3'd6;
  localparam logic [2:0] ALU_SRA = 3'd7;

  localparam logic [1:0] SRC_A_REG   = 2'd0;
  localparam logic [1:0] SRC_A_MEM   = 2'd1;
  localparam logic [1:0] SRC_A_WB    = 2'd2;
  localparam logic [1:0] SRC_A_SHAMT = 2'd3;

  localparam logic [1:0] SRC_B_REG = 2'd0;
  localparam logic [1:0] SRC_B_IMM = 2'd1;
  localparam logic [1:0] SRC_B_MEM = 2'd2;
  localparam logic [1:0] SRC_B_WB  = 2'd3;

  localparam logic [1:0] ST_REG = 2'd0;
  localparam logic [1:0] ST_MEM = 2'd1;
  localparam logic [1:0] ST_WB  = 2'd2;

endpackage

// File: rtl/exe_alu.sv
// Combinational ALU; shifts move b by a[4:0], add/sub wrap silently.
module exe_alu
  import pipe_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [2:0]    aluc,
  output logic [DW-1:0] result
);

  always_comb begin
    result = '0;
    case (aluc)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_SLL: result = b << a[4:0];
      ALU_SRL: result = b >> a[4:0];
      ALU_SRA: result = $unsigned($signed(b) >>> a[4:0]);
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: operand forwarding muxes, ALU, beq/bne resolution with
// mispredict redirect, EXE/MEM pipeline register and branch perf counters.
module exe_stage
  import pipe_pkg::*;
#(
  parameter int DW = 32,
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mem_stall,
  input  logic          ewreg,
  input  logic          em2reg,
  input  logic          ewmem,
  input  logic [2:0]    ealuc,
  input  logic [1:0]    ealusrc_a,
  input  logic [1:0]    ealusrc_b,
  input  logic [1:0]    estore_src,
  input  logic [DW-1:0] eimm,
  input  logic [DW-1:0] ea,
  input  logic [DW-1:0] eb,
  input  logic [4:0]    edest,
  input  logic          eldst_depen,
  input  logic [DW-1:0] ebpc,
  input  logic [DW-1:0] epc4,
  input  logic          ebeq,
  input  logic          ebne,
  input  logic          ebtaken,
  input  logic [DW-1:0] mem_fwd,
  input  logic [DW-1:0] wb_fwd,
  output logic          mispredict,
  output logic [DW-1:0] redirect_pc,
  output logic          mwreg,
  output logic          mm2reg,
  output logic          mwmem,
  output logic [DW-1:0] malu,
  output logic [DW-1:0] mb,
  output logic [4:0]    mdest,
  output logic [CW-1:0] br_count,
  output logic [CW-1:0] mp_count
);

  logic [DW-1:0] op_a, op_b, cmp_b, store_data, alu_result;
  logic          is_branch, taken;

  always_comb begin
    op_a = ea;
    case (ealusrc_a)
      SRC_A_REG:   op_a = ea;
      SRC_A_MEM:   op_a = mem_fwd;
      SRC_A_WB:    op_a = wb_fwd;
      SRC_A_SHAMT: op_a = {{(DW-5){1'b0}}, eimm[10:6]};
      default:     op_a = ea;
    endcase
  end

  // Branch compare uses the forwarded register B, never the immediate.
  always_comb begin
    op_b  = eb;
    cmp_b = eb;
    case (ealusrc_b)
      SRC_B_REG: begin op_b = eb;      cmp_b = eb;      end
      SRC_B_IMM: begin op_b = eimm;    cmp_b = eb;      end
      SRC_B_MEM: begin op_b = mem_fwd; cmp_b = mem_fwd; end
      SRC_B_WB:  begin op_b = wb_fwd;  cmp_b = wb_fwd;  end
      default:   begin op_b = eb;      cmp_b = eb;      end
    endcase
  end

  always_comb begin
    store_data = eb;
    if (eldst_depen) begin
      store_data = wb_fwd;
    end else begin
      case (estore_src)
        ST_REG:  store_data = eb;
        ST_MEM:  store_data = mem_fwd;
        ST_WB:   store_data = wb_fwd;
        default: store_data = eb;
      endcase
    end
  end

  exe_alu #(.DW(DW)) u_alu (
    .a      (op_a),
    .b      (op_b),
    .aluc   (ealuc),
    .result (alu_result)
  );

  // beq has priority so the illegal beq+bne encoding resolves as beq.
  assign is_branch   = ebeq | ebne;
  assign taken       = ebeq ? (op_a == cmp_b) : (ebne & (op_a != cmp_b));
  assign mispredict  = is_branch & (taken != ebtaken);
  assign redirect_pc = taken ? ebpc : epc4;

  always_ff @(posedge clk) begin
    if (rst) begin
      mwreg    <= 1'b0;
      mm2reg   <= 1'b0;
      mwmem    <= 1'b0;
      malu     <= '0;
      mb       <= '0;
      mdest    <= '0;
      br_count <= '0;
      mp_count <= '0;
    end else if (!mem_stall) begin
      mwreg  <= ewreg;
      mm2reg <= em2reg;
      mwmem  <= ewmem;
      malu   <= alu_result;
      mb     <= store_data;
      mdest  <= edest;
      if (is_branch)  br_count <= br_count + CW'(1);
      if (mispredict) mp_count <= mp_count + CW'(1);
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: directed cases plus randomized traffic
// compared against a transaction-level reference model.
module tb_exe_stage;
  import pipe_pkg::*;

  localparam int DW = 32;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst, mem_stall;
  logic          ewreg, em2reg, ewmem;
  logic [2:0]    ealuc;
  logic [1:0]    ealusrc_a, ealusrc_b, estore_src;
  logic [DW-1:0] eimm, ea, eb, ebpc, epc4, mem_fwd, wb_fwd;
  logic [4:0]    edest;
  logic          eldst_depen, ebeq, ebne, ebtaken;
  logic          mispredict;
  logic [DW-1:0] redirect_pc;
  logic          mwreg, mm2reg, mwmem;
  logic [DW-1:0] malu, mb;
  logic [4:0]    mdest;
  logic [CW-1:0] br_count, mp_count;

  always #5 clk = ~clk;

  exe_stage #(.DW(DW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .mem_stall(mem_stall),
    .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem),
    .ealuc(ealuc), .ealusrc_a(ealusrc_a), .ealusrc_b(ealusrc_b),
    .estore_src(estore_src), .eimm(eimm), .ea(ea), .eb(eb),
    .edest(edest), .eldst_depen(eldst_depen), .ebpc(ebpc), .epc4(epc4),
    .ebeq(ebeq), .ebne(ebne), .ebtaken(ebtaken),
    .mem_fwd(mem_fwd), .wb_fwd(wb_fwd),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .mwreg(mwreg), .mm2reg(mm2reg), .mwmem(mwmem),
    .malu(malu), .mb(mb), .mdest(mdest),
    .br_count(br_count), .mp_count(mp_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // reference model state
  logic          exp_wreg, exp_m2reg, exp_wmem;
  logic [31:0]   exp_alu, exp_mb;
  logic [4:0]    exp_dest;
  int unsigned   exp_br, exp_mp;

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int unsigned s;
    s = a % 32;
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return b << s;
      3'd6: return b >> s;
      default: return (b >> s) | (b[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0);
    endcase
  endfunction

  task automatic idle();
    mem_stall = 0; ewreg = 0; em2reg = 0; ewmem = 0;
    ealuc = 0; ealusrc_a = 0; ealusrc_b = 0; estore_src = 0;
    eimm = 0; ea = 0; eb = 0; edest = 0; eldst_depen = 0;
    ebpc = 0; epc4 = 0; ebeq = 0; ebne = 0; ebtaken = 0;
    mem_fwd = 0; wb_fwd = 0;
  endtask

  // Called just after a rising edge with inputs already applied.
  task automatic step();
    logic [31:0] asel[4], bsel[4], csel[4], ssel[4];
    logic [31:0] opa, opb, cmpb, st;
    bit          is_br, tk, mp;
    #2;
    asel = '{ea, mem_fwd, wb_fwd, {27'b0, eimm[10:6]}};
    bsel = '{eb, eimm, mem_fwd, wb_fwd};
    csel = '{eb, eb, mem_fwd, wb_fwd};
    ssel = '{eb, mem_fwd, wb_fwd, eb};
    opa  = asel[ealusrc_a];
    opb  = bsel[ealusrc_b];
    cmpb = csel[ealusrc_b];
    st   = eldst_depen ? wb_fwd : ssel[estore_src];
    is_br = ebeq || ebne;
    tk    = ebeq ? (opa == cmpb) : (ebne && opa != cmpb);
    mp    = is_br && (tk != ebtaken);
    chk("mispredict", mispredict, mp);
    chk("redirect_pc", redirect_pc, tk ? ebpc : epc4);
    if (rst) begin
      exp_wreg = 0; exp_m2reg = 0; exp_wmem = 0;
      exp_alu = 0; exp_mb = 0; exp_dest = 0; exp_br = 0; exp_mp = 0;
    end else if (!mem_stall) begin
      exp_wreg = ewreg; exp_m2reg = em2reg; exp_wmem = ewmem;
      exp_alu = ref_alu(ealuc, opa, opb); exp_mb = st; exp_dest = edest;
      if (is_br) exp_br++;
      if (mp) exp_mp++;
    end
    @(posedge clk);
    #1;
    chk("mwreg", mwreg, exp_wreg);
    chk("mm2reg", mm2reg, exp_m2reg);
    chk("mwmem", mwmem, exp_wmem);
    chk("malu", malu, exp_alu);
    chk("mb", mb, exp_mb);
    chk("mdest", mdest, exp_dest);
    chk("br_count", br_count, exp_br);
    chk("mp_count", mp_count, exp_mp);
  endtask

  initial begin
    logic [31:0] held_alu;
    idle();
    rst = 1;
    step();
    chk("reset malu", malu, 0);
    chk("reset br_count", br_count, 0);
    rst = 0;

    // ADD reg + imm wraps
    ealuc = ALU_ADD; ealusrc_a = SRC_A_REG; ealusrc_b = SRC_B_IMM;
    ea = 5; eimm = 32'hFFFF_FFFF; edest = 3; ewreg = 1;
    step();
    chk("add malu", malu, 4);
    chk("add mdest", mdest, 3);
    chk("add mwreg", mwreg, 1);

    // SUB with forwarded operands
    idle();
    ealuc = ALU_SUB; ealusrc_a = SRC_A_MEM; ealusrc_b = SRC_B_WB;
    mem_fwd = 10; wb_fwd = 3;
    step();
    chk("sub fwd malu", malu, 7);
    eldst_depen = 1; estore_src = ST_MEM; wb_fwd = 32'hAB;
    step();
    chk("ldst_depen mb", mb, 32'hAB);

    // beq mispredicted not-taken
    idle();
    ebeq = 1; ebtaken = 0; ea = 9; eb = 9; ebpc = 32'h100; epc4 = 32'h44;
    #2;
    chk("beq mispredict now", mispredict, 1);
    chk("beq redirect now", redirect_pc, 32'h100);
    step();
    chk("beq br_count", br_count, 1);
    chk("beq mp_count", mp_count, 1);
    ebeq = 0; ebne = 1;
    step();
    chk("bne no mispredict counted", mp_count, 1);

    // shifts
    idle();
    ealuc = ALU_SRA; ealusrc_a = SRC_A_SHAMT; eimm = 32'd4 << 6; eb = 32'h8000_0000;
    step();
    chk("sra malu", malu, 32'hF800_0000);
    ealuc = ALU_SLL; ealusrc_a = SRC_A_REG; ea = 31; eb = 1;
    step();
    chk("sll malu", malu, 32'h8000_0000);

    // stall during a mispredicted beq
    idle();
    ebeq = 1; ebtaken = 0; ea = 7; eb = 7; ebpc = 32'h200; epc4 = 32'h80;
    ealuc = ALU_XOR; edest = 9; mem_stall = 1;
    held_alu = malu;
    for (int i = 0; i < 3; i++) step();
    chk("stall held malu", malu, held_alu);
    chk("stall held br", br_count, 2);
    chk("stall held mp", mp_count, 1);
    mem_stall = 0;
    step();
    chk("release br", br_count, 3);
    chk("release mp", mp_count, 2);
    chk("release mdest", mdest, 9);

    // reset during a stall
    ewreg = 1; edest = 5; mem_stall = 1;
    step();
    rst = 1;
    step();
    chk("rst in stall br", br_count, 0);
    chk("rst in stall mdest", mdest, 0);
    rst = 0;

    // randomized traffic
    for (int n = 0; n < 500; n++) begin
      rst = ($urandom_range(0, 99) < 2);
      mem_stall = ($urandom_range(0, 99) < 20);
      ewreg = $urandom; em2reg = $urandom; ewmem = $urandom;
      ealuc = $urandom; ealusrc_a = $urandom; ealusrc_b = $urandom; estore_src = $urandom;
      eimm = $urandom; ea = $urandom; eb = $urandom; edest = $urandom;
      eldst_depen = ($urandom_range(0, 3) == 0);
      ebpc = $urandom; epc4 = $urandom;
      mem_fwd = $urandom; wb_fwd = $urandom;
      if ($urandom_range(0, 1)) begin eb = ea; mem_fwd = ea; wb_fwd = ea; end
      ebeq = $urandom; ebne = $urandom; ebtaken = $urandom;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
